hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller sitting beside the decode stage. Keeps a per-register scoreboard of in-flight producers (loads, multiplies) whose results cannot be bypassed yet, and detects RAW and WAW hazards against the instruction currently in decode. Stalls fetch/decode and injects bubbles into EX when a hazard is found. Flushes decode on taken branches and jumps.

## Interface
Parameters:
- REG_ADDR, 5, register address width (32 architectural registers)
- MUL_LAT, 5, cycles after issue before a multiply result is bypassable (1..7)
- LD_LAT, 1, cycles after issue before a load result is bypassable (1..7)

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-low; sampled on posedge clk
- dec_valid  in  1  decode holds a real instruction
- dec_src1  in  REG_ADDR  source register 1 of the decode instruction
- dec_src2  in  REG_ADDR  source register 2
- dec_use2  in  1  instruction reads src2 (0 for loads and immediates)
- dec_dest  in  REG_ADDR  destination register
- dec_regwrite  in  1  instruction writes dec_dest
- dec_is_load  in  1  load instruction
- dec_is_mult  in  1  multiply (RTYPE, FN_MUL)
- dec_is_jump  in  1  unconditional jump decoded this cycle
- branch_taken  in  1  taken branch resolved in M stage
- stall  out  1  hold PC and the decode boundary registers
- fetch_we  out  1  equals !stall
- dec_we  out  1  decode boundary write enable; equals !stall
- bubble  out  1  EX receives all-zero control signals this cycle
- flush_id  out  1  invalidate the instruction latched into decode at the next edge

## Operation
- Scoreboard: 32 × 3-bit down-counters cnt[r], plus a 1-bit kind[r] (1 = mult).
- Register 0 is never pending. Writes to cnt[0] are ignored.
- Issue condition: dec_valid & !stall & !flush_id.
- On issue with dec_regwrite & dest≠0:
  - cnt[dest] ← MUL_LAT if dec_is_mult
  - cnt[dest] ← LD_LAT if dec_is_load
  - cnt[dest] ← 0 otherwise (ALU result, bypassed)
  - kind[dest] ← dec_is_mult
- Every cycle, each nonzero cnt not being reloaded decrements by 1. A reload takes priority over the decrement on the same register.
- raw = dec_valid & ((cnt[src1]≠0) | (dec_use2 & cnt[src2]≠0)). A source equal to 0 never hazards.
- waw = dec_valid & dec_regwrite & dest≠0 & cnt[dest] > new latency. Example: an ALU write to a register with a pending mult.
- Stall and bubble:
  - stall = (raw | waw) & !branch_taken
  - bubble = stall | flush_id
- Flush:
  - flush_id = branch_taken | (dec_valid & dec_is_jump & !stall)
  - branch_taken overrides stall. The decode instruction is discarded and does not issue.
  - Counters set by instructions younger than the branch are not cleared. The resulting extra stalls are conservative and accepted.
- Reset (reset=0 at posedge): all cnt and kind cleared. Outputs settle to stall=0, fetch_we=1, dec_we=1, bubble=0 and flush_id=0, provided inputs are idle. Reset mid-stall releases the stall on the next cycle.

## Timing
- stall, fetch_we, dec_we, bubble and flush_id are combinational from the registered scoreboard and the decode inputs. There are no registered outputs.
- A consumer issuing N cycles after its producer stalls for max(0, LAT−N+1) cycles. Example: an immediate load-use pair with LD_LAT=1 stalls 1 cycle.
- Maximum continuous stall is MUL_LAT cycles. There is no deadlock because counters always drain.
- Simultaneous hazards on src1 and src2 stall until both counters reach 0.
- When a producer issues and the next instruction reads the same register in the following cycle, the hazard is seen from the cycle after issue, because cnt is already loaded.

## Configuration
- HAZARD_STATS_EN defined:
  - Adds outputs stall_cycles (32-bit, increments each cycle stall=1) and flush_count (32-bit, increments each cycle flush_id=1).
  - Both counters clear on reset and wrap modulo 2^32.
- HAZARD_STATS_EN undefined: those ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Load r3, next cycle ADD r4←r3,r5 (LD_LAT=1) -> stall=1, bubble=1 for exactly 1 cycle, then dec_we=1 and ADD issues.
- MUL r2, then immediately ADD using r2 (MUL_LAT=5) -> stall held 5 consecutive cycles; stall_cycles=5 with HAZARD_STATS_EN.
- MUL r7, then ALU write to r7 -> WAW stall until cnt[r7]≤0; independent ALU ops on r8 issue without stall.
- Stalled consumer with branch_taken=1 -> stall=0, flush_id=1, bubble=1; consumer does not issue, scoreboard unchanged except for decrement.
- Jump in decode with no hazard -> flush_id=1 for 1 cycle, fetch_we=1; jump with pending src hazard -> stall first, flush only when stall drops.
- reset=0 during a MUL-induced stall -> next cycle stall=0, all cnt=0; read of r0 after load to r0 never stalls.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage RAW/WAW hazard detection against a scoreboard of in-flight producers.
// Define HAZARD_STATS_EN to add the stall_cycles/flush_count performance counters.
module hazard_ctrl #(
    parameter int REG_ADDR = 5,
    parameter int MUL_LAT  = 5,
    parameter int LD_LAT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dec_valid,
    input  logic [REG_ADDR-1:0] dec_src1,
    input  logic [REG_ADDR-1:0] dec_src2,
    input  logic                dec_use2,
    input  logic [REG_ADDR-1:0] dec_dest,
    input  logic                dec_regwrite,
    input  logic                dec_is_load,
    input  logic                dec_is_mult,
    input  logic                dec_is_jump,
    input  logic                branch_taken,
    output logic                stall,
    output logic                fetch_we,
    output logic                dec_we,
    output logic                bubble,
    output logic                flush_id
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         flush_count
`endif
);
    localparam int NREG = 1 << REG_ADDR;
    localparam logic [2:0] MUL_CNT = 3'(MUL_LAT);
    localparam logic [2:0] LD_CNT  = 3'(LD_LAT);
    logic [NREG-1:0][2:0] cnt;
    logic [NREG-1:0]      kind;
    logic [2:0]           new_lat;
    logic                 raw, waw, issue_wr;
    always_comb begin
        new_lat  = dec_is_mult ? MUL_CNT : dec_is_load ? LD_CNT : 3'd0;
        raw      = dec_valid & ((cnt[dec_src1] != 3'd0) | (dec_use2 & (cnt[dec_src2] != 3'd0)));
        waw      = dec_valid & dec_regwrite & (dec_dest != '0) & (cnt[dec_dest] > new_lat);
        stall    = (raw | waw) & ~branch_taken;
        flush_id = branch_taken | (dec_valid & dec_is_jump & ~stall);
        bubble   = stall | flush_id;
        fetch_we = ~stall;
        dec_we   = ~stall;
        issue_wr = dec_valid & ~stall & ~flush_id & dec_regwrite & (dec_dest != '0);
    end
    // Entry 0 is never written, so r0 can never report a pending producer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            kind <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (issue_wr && dec_dest == REG_ADDR'(i)) begin
                    cnt[i]  <= new_lat;
                    kind[i] <= dec_is_mult;
                end else if (cnt[i] != 3'd0) begin
                    cnt[i] <= cnt[i] - 3'd1;
                end
            end
        end
    end
    // A non-multiply entry can never hold more than a load's latency.
    for (genvar g = 0; g < NREG; g++) begin : g_kind
        a_kind: assert property (@(posedge clk) disable iff (!reset) !kind[g] |-> cnt[g] <= LD_CNT);
    end
`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            stall_cycles <= stall_cycles + 32'(stall);
            flush_count  <= flush_count + 32'(flush_id);
        end
    end
`endif
endmodule
